// File: rtl/twenty_bit_bitwise_or_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit OR unit between two requesters.
// The result is tagged with the owning requester id and held until acknowledged.
module twenty_bit_bitwise_or_arbiter #(
  parameter int WIDTH     = 20,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 resp_valid,
  output logic                 resp_id,
  output logic [WIDTH-1:0]     resp_data,
  input  logic                 resp_ready,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               last_grant_r;
  logic               grant_valid_s;
  logic               grant_id_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               id_r;

  // Grant selection: only in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == IDLE) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b0;
        end
        2'b10: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b1;
        end
        2'b11: begin
          grant_valid_s = 1'b1;
          grant_id_s    = ~last_grant_r;
        end
        default: begin
          grant_valid_s = 1'b0;
          grant_id_s    = 1'b0;
        end
      endcase
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // A grant implies the chosen requester's valid is high, so ready == transfer.
  assign req0_ready = grant_valid_s & ~grant_id_s;
  assign req1_ready = grant_valid_s &  grant_id_s;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and arbitration history; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      if (grant_valid_s) begin
        last_grant_r <= grant_id_s;
      end
    end
  end

  // Operand capture on transfer, OR evaluation in EXEC, result hold until ack in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      id_r       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            a_r  <= grant_id_s ? req1_a : req0_a;
            b_r  <= grant_id_s ? req1_b : req0_b;
            id_r <= grant_id_s;
          end
        end
        EXEC: begin
          resp_data  <= a_r | b_r;
          resp_id    <= id_r;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

  // Completed-response counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= {CNT_WIDTH{1'b0}};
    end else if ((state_r == RESP) && resp_ready) begin
      op_count <= op_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_twenty_bit_bitwise_or_arbiter.sv
// Self-checking bench for twenty_bit_bitwise_or_arbiter: vector table plus
// hand-written sequences, with a response scoreboard queue.
module tb_twenty_bit_bitwise_or_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [19:0] req0_a;
  logic [19:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [19:0] req1_a;
  logic [19:0] req1_b;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [19:0] resp_data;
  logic        resp_ready;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int n_resp = 0;
  logic [20:0] exp_q[$];
  logic [7:0]  exp_count;

  typedef struct {
    logic        id;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] exp;
  } vec_t;
  vec_t vecs[6];

  twenty_bit_bitwise_or_arbiter #(.WIDTH(20), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (resp_valid && resp_ready) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          chk("resp_id", {31'd0, resp_id}, {31'd0, e[20]});
          chk("resp_data", {12'd0, resp_data}, {12'd0, e[19:0]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 20 && !resp_valid; i++) tick();
    chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  // Drives one requester from IDLE and completes the transfer edge.
  task automatic start_op(input logic id, input logic [19:0] a, input logic [19:0] b,
                          input logic [19:0] exp);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, ~id});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, id});
    exp_q.push_back({id, exp});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Full op with resp_ready high: checks the 2-edge latency and the ack.
  task automatic do_op(input logic id, input logic [19:0] a, input logic [19:0] b,
                       input logic [19:0] exp);
    start_op(id, a, b, exp);
    chk("lat_exec", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("lat_resp", {31'd0, resp_valid}, 32'd1);
    tick();
    chk("ack_drop", {31'd0, resp_valid}, 32'd0);
    exp_count = exp_count + 8'd1;
    chk("op_count", {24'd0, op_count}, {24'd0, exp_count});
  endtask

  initial begin
    int t_prev;
    vecs[0] = '{1'b0, 20'h0005F, 20'h00000, 20'h0005F};
    vecs[1] = '{1'b1, 20'h0A0A0, 20'h05050, 20'h0F0F0};
    vecs[2] = '{1'b0, 20'h00000, 20'h00000, 20'h00000};
    vecs[3] = '{1'b1, 20'hFFFFF, 20'h00001, 20'hFFFFF};
    vecs[4] = '{1'b0, 20'h80000, 20'h00001, 20'h80001};
    vecs[5] = '{1'b1, 20'h12345, 20'h54321, 20'h56365};

    rst = 1'b1; resp_ready = 1'b0; exp_count = 8'd0;
    req0_valid = 1'b0; req0_a = 20'h0; req0_b = 20'h0;
    req1_valid = 1'b0; req1_a = 20'h0; req1_b = 20'h0;
    #12;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", {12'd0, resp_data}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Single transfers from the vector table.
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Both valid continuously: alternate 0,1,0,1 at one response per 3 cycles.
    req0_valid = 1'b1; req0_a = 20'hC0003; req0_b = 20'hC0003;
    req1_valid = 1'b1; req1_a = 20'hFFFFF; req1_b = 20'h00000;
    exp_q.push_back({1'b0, 20'hC0003});
    exp_q.push_back({1'b1, 20'hFFFFF});
    exp_q.push_back({1'b0, 20'hC0003});
    exp_q.push_back({1'b1, 20'hFFFFF});
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_resp();
      if (k > 0) chk("issue_interval", cycle - t_prev, 32'd3);
      t_prev = cycle;
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    exp_count = exp_count + 8'd4;
    chk("alt_op_count", {24'd0, op_count}, {24'd0, exp_count});
    chk("alt_q_empty", exp_q.size(), 32'd0);

    // Backpressure: hold result 5 cycles while req0 operands change.
    resp_ready = 1'b0;
    start_op(1'b0, 20'h00F00, 20'h000F0, 20'h00FF0);
    wait_resp();
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_a = 20'h11111 << k; req0_b = 20'h0000F;
      #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data", {12'd0, resp_data}, 32'h00FF0);
      chk("bp_id", {31'd0, resp_id}, 32'd0);
      chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("bp_count", {24'd0, op_count}, {24'd0, exp_count});
      tick();
    end
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    chk("bp_done", {31'd0, resp_valid}, 32'd0);
    chk("bp_op_count", {24'd0, op_count}, {24'd0, exp_count});
    tick(); tick();
    chk("bp_single", {31'd0, resp_valid}, 32'd0);
    chk("bp_q_empty", exp_q.size(), 32'd0);

    // req1 valid pulsed only during EXEC must not transfer.
    start_op(1'b0, 20'h00A00, 20'h00005, 20'h00A05);
    req1_valid = 1'b1; req1_a = 20'h77777; req1_b = 20'h00000;
    #1;
    chk("pulse_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req1_valid = 1'b0;
    chk("pulse_resp", {31'd0, resp_valid}, 32'd1);
    tick();
    exp_count = exp_count + 8'd1;
    tick(); tick(); tick();
    chk("pulse_no_extra", {31'd0, resp_valid}, 32'd0);
    chk("pulse_q_empty", exp_q.size(), 32'd0);
    do_op(1'b0, 20'h00000, 20'h00000, 20'h00000);

    // Reset during RESP aborts the result immediately, without a clock edge.
    resp_ready = 1'b0;
    start_op(1'b1, 20'h0F0F0, 20'h00000, 20'h0F0F0);
    wait_resp();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_count", {24'd0, op_count}, 32'd0);
    chk("abort_data", {12'd0, resp_data}, 32'd0);
    exp_q.delete();
    exp_count = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // 256 back-to-back ops wrap op_count back to 0.
    resp_ready = 1'b1;
    for (int k = 0; k < 256; k++) do_op(1'b1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    chk("wrap_zero", {24'd0, op_count}, 32'd0);
    chk("wrap_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
